// File: rtl/vscale_hasti_sram_slave.sv
// -----------------------------------------------------------------------------
// vscale_hasti_sram_slave
//
// AHB-Lite (HASTI) single-port SRAM slave with optional wait states.
// An accepted address phase is registered. Its data phase is served from the
// registered copy: it can be delayed by WAIT_CYCLES wait states, or answered
// with a two-cycle ERROR response when the transfer is out of range or
// misaligned. Storage is not reset.
//
// Parameters
//   NWORDS       storage depth in 32-bit words
//   WAIT_CYCLES  wait states inserted before each OKAY data phase (0..15)
//
// Ports
//   hclk       in   bus clock, rising edge
//   hresetn    in   asynchronous active-low reset
//   hsel       in   slave select
//   haddr      in   byte address
//   hwrite     in   1 = write
//   hsize      in   0 = byte, 1 = half, 2 = word
//   hburst     in   ignored
//   hmastlock  in   ignored
//   hprot      in   ignored
//   htrans     in   0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
//   hwdata     in   write data (data phase)
//   hready     in   bus-level ready
//   hrdata     out  read data (DATA state of a read, otherwise 0)
//   hreadyout  out  slave ready
//   hresp      out  0 = OKAY, 1 = ERROR
// -----------------------------------------------------------------------------
module vscale_hasti_sram_slave #(
    parameter int NWORDS      = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int          AW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [31:0] NWORDS_L  = 32'(NWORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    // Byte lanes written by a transfer of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << off;
            3'd1:    m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic        write_q;
    logic [2:0]  size_q;
    logic [31:0] mem_q [NWORDS];

    logic          accept_s;
    logic          bad_s;
    logic          wr_en_s;
    logic [3:0]    be_s;
    logic [AW-1:0] word_idx_s;
    logic          unused_s;

    // hreadyout is low in WAIT/ERR1, which keeps hready low on the bus; gating
    // with it as well guarantees those stalled address phases are never taken.
    assign accept_s = hsel & hready & htrans[1] & hreadyout;

    assign bad_s = ({2'b00, haddr[31:2]} >= NWORDS_L)
                 | (hsize > 3'd2)
                 | ((hsize == 3'd1) & haddr[0])
                 | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

    assign word_idx_s = addr_q[AW+1:2];
    assign be_s       = lane_mask(size_q, addr_q[1:0]);
    // Write commits on the edge that ends DATA; an async reset before that edge
    // forces IDLE and so drops the write.
    assign wr_en_s    = (state_q == ST_DATA) & write_q;

    assign unused_s = ^{hburst, hmastlock, hprot, addr_q, size_q};

    // State and wait-counter register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: acceptance always restarts the sequence; otherwise the
    // current data phase runs to completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept_s) begin
            if (bad_s) begin
                state_d = ST_ERR1;
                cnt_d   = 4'd0;
            end else if (WAIT_CYCLES == 0) begin
                state_d = ST_DATA;
                cnt_d   = 4'd0;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_INIT;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_DATA;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_DATA: state_d = ST_IDLE;
                ST_ERR1: state_d = ST_ERR2;
                ST_ERR2: state_d = ST_IDLE;
                ST_IDLE: state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = 32'd0;
        case (state_q)
            ST_IDLE: begin
                hreadyout = 1'b1;
            end
            ST_WAIT: begin
                hreadyout = 1'b0;
            end
            ST_DATA: begin
                if (!write_q) begin
                    hrdata = mem_q[word_idx_s];
                end else begin
                    hrdata = 32'd0;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: begin
                hresp = 1'b1;
            end
            default: begin
                hreadyout = 1'b1;
            end
        endcase
    end

    // Registered address phase, captured on acceptance.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else if (accept_s) begin
            addr_q  <= haddr;
            write_q <= hwrite;
            size_q  <= hsize;
        end
    end

    // Storage array, byte-lane write; intentionally not reset.
    always_ff @(posedge hclk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[word_idx_s][i*8 +: 8] <= hwdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_vscale_hasti_sram_slave
//
// Two slaves: index 0 with WAIT_CYCLES = 0, index 1 with WAIT_CYCLES = 3.
// Each has its own bus signals. A pipelined AHB master replays a queue of
// transfers. A transfer-level reference model predicts the response:
//   - length of each data phase,
//   - OKAY or ERROR,
//   - read data, taken from a byte-addressed memory image.
// -----------------------------------------------------------------------------
module tb_vscale_hasti_sram_slave;

    localparam int NW = 1024;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        hclk    = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel_s      [2];
    logic [31:0] haddr_s     [2];
    logic        hwrite_s    [2];
    logic [2:0]  hsize_s     [2];
    logic [2:0]  hburst_s    [2];
    logic        hmastlock_s [2];
    logic [3:0]  hprot_s     [2];
    logic [1:0]  htrans_s    [2];
    logic [31:0] hwdata_s    [2];
    logic        hready_s    [2];
    logic [31:0] hrdata_s    [2];
    logic        hreadyout_s [2];
    logic        hresp_s     [2];

    int n_vec = 0;
    int n_err = 0;

    xfer_t      xq[$];
    logic [7:0] mref [int];

    always #5 hclk = ~hclk;

    vscale_hasti_sram_slave #(.NWORDS(NW), .WAIT_CYCLES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_s[0]), .haddr(haddr_s[0]),
        .hwrite(hwrite_s[0]), .hsize(hsize_s[0]), .hburst(hburst_s[0]),
        .hmastlock(hmastlock_s[0]), .hprot(hprot_s[0]), .htrans(htrans_s[0]),
        .hwdata(hwdata_s[0]), .hready(hready_s[0]), .hrdata(hrdata_s[0]),
        .hreadyout(hreadyout_s[0]), .hresp(hresp_s[0])
    );

    vscale_hasti_sram_slave #(.NWORDS(NW), .WAIT_CYCLES(3)) u_dut3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_s[1]), .haddr(haddr_s[1]),
        .hwrite(hwrite_s[1]), .hsize(hsize_s[1]), .hburst(hburst_s[1]),
        .hmastlock(hmastlock_s[1]), .hprot(hprot_s[1]), .htrans(htrans_s[1]),
        .hwdata(hwdata_s[1]), .hready(hready_s[1]), .hrdata(hrdata_s[1]),
        .hreadyout(hreadyout_s[1]), .hresp(hresp_s[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int waits_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit is_acc(input xfer_t x);
        return x.sel && x.trans[1];
    endfunction

    function automatic bit is_bad(input xfer_t x);
        int unsigned a;
        a = x.addr;
        if ((a / 4) >= NW)                 return 1'b1;
        if (x.size > 3'd2)                 return 1'b1;
        if (x.size == 3'd1 && (a % 2) != 0) return 1'b1;
        if (x.size == 3'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Cycles from the first data-phase cycle up to and including the ready one.
    function automatic int dp_len(input int d, input xfer_t x);
        if (!is_acc(x)) return 1;
        if (is_bad(x))  return 2;
        return waits_of(d) + 1;
    endfunction

    function automatic int mkey(input int d, input int unsigned byte_addr);
        return d * 32'h0010_0000 + int'(byte_addr);
    endfunction

    function automatic logic [31:0] ref_word(input int d, input logic [31:0] a, output bit known);
        logic [31:0] w;
        int unsigned base;
        base  = int'(a) - (int'(a) % 4);
        known = 1'b1;
        w     = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (mref.exists(mkey(d, base + b))) begin
                w[8*b +: 8] = mref[mkey(d, base + b)];
            end else begin
                known = 1'b0;
            end
        end
        return w;
    endfunction

    task automatic ref_write(input int d, input xfer_t x);
        int unsigned off;
        int unsigned base;
        bit          en;
        off  = int'(x.addr) % 4;
        base = int'(x.addr) - off;
        for (int b = 0; b < 4; b++) begin
            en = (x.size == 3'd2) || (x.size == 3'd1 && (b / 2) == (off / 2)) ||
                 (x.size == 3'd0 && b == off);
            if (en) mref[mkey(d, base + b)] = x.wdata[8*b +: 8];
        end
    endtask

    task automatic push(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic wr, input logic [2:0] sz, input logic [31:0] wd);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.addr = a; x.wr = wr; x.size = sz; x.wdata = wd;
        xq.push_back(x);
    endtask

    task automatic drive_idle(input int d);
        hsel_s[d]   = 1'b0;
        htrans_s[d] = 2'd0;
        haddr_s[d]  = 32'd0;
        hwrite_s[d] = 1'b0;
        hsize_s[d]  = 3'd0;
        hready_s[d] = 1'b1;
    endtask

    task automatic drive_addr(input int d, input xfer_t x);
        hsel_s[d]      = x.sel;
        htrans_s[d]    = x.trans;
        haddr_s[d]     = x.addr;
        hwrite_s[d]    = x.wr;
        hsize_s[d]     = x.size;
        hburst_s[d]    = 3'($urandom_range(0, 7));
        hprot_s[d]     = 4'($urandom_range(0, 15));
        hmastlock_s[d] = 1'($urandom_range(0, 1));
    endtask

    // Pipelined master: the next address phase is held from the start of the
    // current data phase and is taken on the cycle the slave is ready.
    // Entered and left just after a rising edge.
    task automatic run_q(input int d);
        xfer_t       cur;
        bit          cur_v;
        int          cyc;
        int          len;
        int          idx;
        bit          last;
        bit          known;
        logic [31:0] exp_dat;
        cur_v = 1'b0; cyc = 0; len = 0; idx = 0;
        while (idx < xq.size() || cur_v) begin
            last = !cur_v || (cyc == len - 1);
            if (idx < xq.size()) drive_addr(d, xq[idx]);
            else                 drive_idle(d);
            hready_s[d] = last;
            hwdata_s[d] = cur_v ? cur.wdata : $urandom();
            @(negedge hclk);
            exp_dat = 32'd0;
            known   = 1'b1;
            if (cur_v && is_acc(cur) && !is_bad(cur) && !cur.wr && last) begin
                exp_dat = ref_word(d, cur.addr, known);
            end
            check_val($sformatf("hreadyout[%0d]", d), 32'(hreadyout_s[d]), 32'(last));
            check_val($sformatf("hresp[%0d]", d), 32'(hresp_s[d]),
                      32'(cur_v && is_acc(cur) && is_bad(cur)));
            if (known) check_val($sformatf("hrdata[%0d]@%h", d, cur.addr), hrdata_s[d], exp_dat);
            if (last) begin
                if (cur_v && is_acc(cur) && !is_bad(cur) && cur.wr) ref_write(d, cur);
                if (idx < xq.size()) begin
                    cur   = xq[idx];
                    idx++;
                    cur_v = 1'b1;
                    cyc   = 0;
                    len   = dp_len(d, cur);
                end else begin
                    cur_v = 1'b0;
                end
            end else begin
                cyc++;
            end
            @(posedge hclk);
            #1;
        end
        drive_idle(d);
        xq.delete();
    endtask

    task automatic push_random();
        int          k;
        int          r;
        logic [31:0] w4;
        logic [2:0]  sz;
        logic [31:0] off;
        k  = $urandom_range(0, 9);
        r  = $urandom_range(0, 3);
        w4 = 32'($urandom_range(0, 15)) * 32'd4;
        if (k == 0) begin
            if (r == 0)      push(1'b0, {1'b1, 1'($urandom_range(0, 1))}, 32'h40 + w4, 1'b0, 3'd2, 32'd0);
            else if (r == 1) push(1'b1, 2'd0, 32'h40 + w4, 1'b1, 3'd2, $urandom());
            else             push(1'b1, 2'd1, 32'h40 + w4, 1'b0, 3'd2, 32'd0);
        end else if (k == 1) begin
            if (r == 0)      push(1'b1, 2'd2, 32'h1000 + w4, 1'($urandom_range(0, 1)), 3'd2, $urandom());
            else if (r == 1) push(1'b1, 2'd2, 32'h40 + w4, 1'($urandom_range(0, 1)), 3'd3, $urandom());
            else if (r == 2) push(1'b1, 2'd2, 32'h41 + w4, 1'($urandom_range(0, 1)), 3'd1, $urandom());
            else             push(1'b1, 2'd2, 32'h40 + w4 + 32'($urandom_range(1, 3)),
                                  1'($urandom_range(0, 1)), 3'd2, $urandom());
        end else begin
            sz = 3'($urandom_range(0, 2));
            if (sz == 3'd2)      off = 32'd0;
            else if (sz == 3'd1) off = 32'($urandom_range(0, 1)) * 32'd2;
            else                 off = 32'($urandom_range(0, 3));
            push(1'b1, {1'b1, 1'($urandom_range(0, 1))}, 32'h40 + w4 + off,
                 1'($urandom_range(0, 1)), sz, $urandom());
        end
    endtask

    task automatic random_run(input int d, input int n);
        for (int i = 0; i < 16; i++) push(1'b1, 2'd2, 32'h40 + 32'(i) * 32'd4, 1'b1, 3'd2, $urandom());
        for (int i = 0; i < n; i++) push_random();
        run_q(d);
    endtask

    task automatic error_run(input int d);
        push(1'b1, 2'd2, 32'h00, 1'b1, 3'd2, 32'hCAFE_F00D);
        push(1'b1, 2'd2, 32'h1000, 1'b0, 3'd2, 32'd0);
        push(1'b1, 2'd2, 32'h02, 1'b1, 3'd2, 32'h1234_5678);
        push(1'b1, 2'd2, 32'h00, 1'b0, 3'd2, 32'd0);
        run_q(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            drive_idle(d);
            hwdata_s[d]    = 32'd0;
            hburst_s[d]    = 3'd0;
            hprot_s[d]     = 4'd0;
            hmastlock_s[d] = 1'b0;
        end
        hresetn = 1'b0;
        repeat (3) @(negedge hclk);
        for (int d = 0; d < 2; d++) begin
            check_val("rst_hreadyout", 32'(hreadyout_s[d]), 32'd1);
            check_val("rst_hresp", 32'(hresp_s[d]), 32'd0);
            check_val("rst_hrdata", hrdata_s[d], 32'd0);
        end
        @(posedge hclk);
        #1;
        hresetn = 1'b1;

        // Zero-wait write then back-to-back read of the same word.
        push(1'b1, 2'd2, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
        push(1'b1, 2'd2, 32'h10, 1'b0, 3'd2, 32'd0);
        run_q(0);
        // Byte merge into an existing word.
        push(1'b1, 2'd2, 32'h10, 1'b1, 3'd2, 32'h1122_3344);
        push(1'b1, 2'd3, 32'h13, 1'b1, 3'd0, 32'hAA00_0000);
        push(1'b1, 2'd2, 32'h10, 1'b0, 3'd2, 32'd0);
        run_q(0);
        error_run(0);
        // IDLE/BUSY selected and NONSEQ unselected, then a normal read.
        push(1'b1, 2'd0, 32'h10, 1'b1, 3'd2, 32'h0BAD_0BAD);
        push(1'b1, 2'd1, 32'h10, 1'b1, 3'd2, 32'h0BAD_0BAD);
        push(1'b0, 2'd2, 32'h10, 1'b1, 3'd2, 32'h0BAD_0BAD);
        push(1'b1, 2'd2, 32'h10, 1'b0, 3'd2, 32'd0);
        run_q(0);
        random_run(0, 200);

        // Three wait states.
        push(1'b1, 2'd2, 32'h30, 1'b1, 3'd2, 32'h5555_AAAA);
        push(1'b1, 2'd2, 32'h30, 1'b0, 3'd2, 32'd0);
        run_q(1);
        error_run(1);
        random_run(1, 150);

        // Reset during the second wait cycle of a write must drop the write.
        push(1'b1, 2'd2, 32'h20, 1'b1, 3'd2, 32'h0000_0000);
        run_q(1);
        hsel_s[1] = 1'b1; haddr_s[1] = 32'h20; hwrite_s[1] = 1'b1;
        hsize_s[1] = 3'd2; htrans_s[1] = 2'd2; hready_s[1] = 1'b1;
        @(posedge hclk);
        #1;
        drive_idle(1);
        hready_s[1] = 1'b0;
        hwdata_s[1] = 32'h5A5A_5A5A;
        check_val("wait1_hreadyout", 32'(hreadyout_s[1]), 32'd0);
        @(posedge hclk);
        #1;
        check_val("wait2_hreadyout", 32'(hreadyout_s[1]), 32'd0);
        #2;
        hresetn = 1'b0;
        #1;
        check_val("async_rst_hreadyout", 32'(hreadyout_s[1]), 32'd1);
        check_val("async_rst_hresp", 32'(hresp_s[1]), 32'd0);
        check_val("async_rst_hrdata", hrdata_s[1], 32'd0);
        @(posedge hclk);
        #1;
        hresetn     = 1'b1;
        hready_s[1] = 1'b1;
        push(1'b1, 2'd2, 32'h20, 1'b0, 3'd2, 32'd0);
        run_q(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vscale_hasti_sram_slave.md
VSCALE_HASTI_SRAM_SLAVE -- requirements
Module: vscale_hasti_sram_slave

Interface
REQ-001 SHALL have parameter NWORDS, default 1024, giving the storage depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, giving the number of inserted wait states per OKAY data phase (range 0..15).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- hclk  in  1  bus clock, all state on the rising edge
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  32  byte address
- hwrite  in  1  1 = write
- hsize  in  3  0 = byte, 1 = half, 2 = word
- hburst  in  3  ignored
- hmastlock  in  1  ignored
- hprot  in  4  ignored
- htrans  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
- hwdata  in  32  write data, valid in the data phase
- hready  in  1  bus-level ready
- hrdata  out  32  read data
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR

Function
REQ-005 SHALL accept an address phase only when hsel=1, hready=1 and htrans[1]=1.
REQ-006 SHALL register haddr, hwrite and hsize on acceptance for use in the data phase.
REQ-007 SHALL treat IDLE/BUSY, or an unselected cycle, as a zero-wait OKAY with no storage access.
REQ-008 SHALL flag an accepted transfer as bad on any of:
- haddr[31:2] >= NWORDS
- hsize > 2
- hsize = 1 with haddr[0] = 1
- hsize = 2 with haddr[1:0] != 0
REQ-009 SHALL implement the states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-010 State transitions on acceptance from IDLE, DATA or ERR2:
- bad transfer -> ERR1
- WAIT_CYCLES = 0 -> DATA
- otherwise -> WAIT, with the wait counter loaded to WAIT_CYCLES-1
REQ-011 State transitions without acceptance:
- WAIT: decrement the counter; go to DATA when it reaches 0
- DATA -> IDLE
- ERR1 -> ERR2
- ERR2 -> IDLE
REQ-012 SHALL drive outputs per state:
- IDLE: hreadyout=1, hresp=0
- WAIT: hreadyout=0, hresp=0
- DATA: hreadyout=1, hresp=0
- ERR1: hreadyout=0, hresp=1
- ERR2: hreadyout=1, hresp=1
REQ-013 SHALL ignore address phases presented while hreadyout=0, because hready is low on the bus during those cycles.
REQ-014 For a write, SHALL update storage only at the rising edge ending DATA, using the registered address and hwdata.
REQ-015 Write byte-lane enables:
- byte: lane haddr[1:0]
- half: lanes {haddr[1],0} and {haddr[1],1}
- word: all lanes
REQ-016 For a read in DATA, SHALL drive hrdata with the full stored word at the registered word address, unshifted; otherwise hrdata SHALL be 0.
REQ-017 A read accepted in the same cycle that a write completes to the same word SHALL return the newly written data.
REQ-018 ERR1/ERR2 SHALL perform no storage write.
REQ-019 A transfer accepted during ERR2 SHALL be processed normally.
REQ-020 A transfer whose data phase ends at DATA or ERR2 while a new one is accepted SHALL chain back-to-back with no idle cycle.
REQ-021 Storage contents SHALL NOT be affected by reset and are undefined at power-up.

Reset
REQ-022 While hresetn=0: state = IDLE, hreadyout=1, hresp=0, hrdata=0, registered address phase cleared, wait counter = 0.
REQ-023 Reset asserted mid-WAIT or mid-ERR1 SHALL abort the transfer immediately with no storage write.
REQ-024 After reset release, SHALL accept an address phase on the first rising edge.

Verification
REQ-025 WAIT_CYCLES=0: word write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read data phase hrdata=0xDEADBEEF, hreadyout=1 throughout, hresp=0.
REQ-026 Byte write 0xAA to 0x13 over stored 0x11223344, then word read of 0x10 -> hrdata=0xAA223344.
REQ-027 WAIT_CYCLES=3: word read -> hreadyout low for exactly 3 cycles, then 1 cycle high with valid hrdata.
REQ-028 NWORDS=1024: read haddr=0x1000 -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), then IDLE; a misaligned word write to 0x02 produces the same response and leaves storage unchanged.
REQ-029 Pull hresetn low during the 2nd wait cycle of a write to 0x20 holding 0x0 -> outputs reset asynchronously, and a later read of 0x20 returns 0x0.
REQ-030 BUSY and IDLE htrans with hsel=1, and NONSEQ with hsel=0 -> hreadyout=1, hresp=0, no state change.
